// File: rtl/ecpu_fabric_bridge.sv
// CPU-side bridge for the E_CPU_IO eFPGA tile: serialises an operand pair onto OPA/OPB
// as nibbles, then reassembles the tile's nibble-serial result into one response word.
module ecpu_fabric_bridge #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic              UserCLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [3:0]        resp_flags,
    output logic [1:0]        resp_err,
    output logic [3:0]        OPA_I,
    output logic [3:0]        OPB_I,
    input  logic [3:0]        RES0_O,
    input  logic [3:0]        RES1_O,
    input  logic [3:0]        RES2_O
);

    localparam int NB   = DATA_W / 4;
    localparam int BC_W = $clog2(2 * NB + 1);
    localparam int R_W  = $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            res0_r;
    logic [3:0]            res1_r;
    logic [3:0]            res2_r;
    logic [2*DATA_W-1:0]   shift_r;
    logic [BC_W-1:0]       beat_r;
    logic [R_W-1:0]        slot_r;
    logic [TO_W-1:0]       to_cnt_r;
    logic [DATA_W-1:0]     result_r;
    logic                  err_r;
    logic                  ovf_r;
    logic                  beat_valid_s;
    logic                  beat_last_s;
    logic                  timeout_s;
    logic [3:0]            ctrl_s;
    logic [DATA_W-1:0]     result_upd_s;
    logic                  err_upd_s;
    logic                  ovf_upd_s;
    logic [1:0]            code_s;

    assign req_ready    = (state_r == S_IDLE);
    assign beat_valid_s = (state_r == S_WAIT) && res1_r[0];
    assign beat_last_s  = beat_valid_s && res1_r[1];
    assign timeout_s    = (to_cnt_r == TO_W'(TIMEOUT - 1));

    // Input capture stage for the tile result pins.
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            res0_r <= 4'h0;
            res1_r <= 4'h0;
            res2_r <= 4'h0;
        end else begin
            res0_r <= RES0_O;
            res1_r <= RES1_O;
            res2_r <= RES2_O;
        end
    end

    // State register.
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) state_nxt_s = S_SEND;
                else           state_nxt_s = S_IDLE;
            end
            S_SEND: begin
                if (beat_r == BC_W'(2 * NB)) state_nxt_s = S_WAIT;
                else                         state_nxt_s = S_SEND;
            end
            S_WAIT: begin
                if (beat_last_s)                     state_nxt_s = S_RESP;
                else if (!beat_valid_s && timeout_s) state_nxt_s = S_RESP;
                else                                 state_nxt_s = S_WAIT;
            end
            S_RESP: begin
                if (resp_ready) state_nxt_s = S_IDLE;
                else            state_nxt_s = S_RESP;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Control nibble for the beat about to be driven, and the result/status after the current beat.
    always_comb begin
        ctrl_s = 4'h9;
        if (beat_r < BC_W'(NB))                ctrl_s = 4'h8;
        else if (beat_r == BC_W'(2 * NB - 1))  ctrl_s = 4'hD;
        else                                   ctrl_s = 4'h9;
        // Slot NB is the overflow position: nothing is written there.
        for (int k = 0; k < NB; k++) begin
            result_upd_s[4*k +: 4] = (beat_valid_s && (slot_r == R_W'(k))) ? res0_r : result_r[4*k +: 4];
        end
        err_upd_s = err_r | (beat_valid_s & res1_r[2]);
        ovf_upd_s = ovf_r | (beat_valid_s && (slot_r == R_W'(NB)));
        if (err_upd_s)      code_s = 2'd1;
        else if (ovf_upd_s) code_s = 2'd3;
        else                code_s = 2'd0;
    end

    // Datapath: operand serialiser, result collector and response registers.
    always_ff @(posedge UserCLK or posedge reset) begin
        if (reset) begin
            shift_r    <= '0;
            beat_r     <= '0;
            slot_r     <= '0;
            to_cnt_r   <= '0;
            result_r   <= '0;
            err_r      <= 1'b0;
            ovf_r      <= 1'b0;
            OPA_I      <= 4'h0;
            OPB_I      <= 4'h0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_flags <= 4'h0;
            resp_err   <= 2'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        shift_r  <= {req_b, req_a} >> 4;
                        OPA_I    <= req_a[3:0];
                        OPB_I    <= 4'h8;
                        beat_r   <= BC_W'(1);
                        slot_r   <= '0;
                        result_r <= '0;
                        err_r    <= 1'b0;
                        ovf_r    <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (beat_r == BC_W'(2 * NB)) begin
                        OPA_I    <= 4'h0;
                        OPB_I    <= 4'h0;
                        to_cnt_r <= '0;
                    end else begin
                        OPA_I   <= shift_r[3:0];
                        OPB_I   <= ctrl_s;
                        shift_r <= shift_r >> 4;
                        beat_r  <= beat_r + BC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (beat_valid_s) begin
                        result_r <= result_upd_s;
                        err_r    <= err_upd_s;
                        ovf_r    <= ovf_upd_s;
                        to_cnt_r <= '0;
                        if (slot_r != R_W'(NB)) slot_r <= slot_r + R_W'(1);
                        if (beat_last_s) begin
                            resp_valid <= 1'b1;
                            resp_data  <= result_upd_s;
                            resp_flags <= res2_r;
                            resp_err   <= code_s;
                        end
                    end else if (timeout_s) begin
                        // No last beat was seen, so there are no flags to report.
                        resp_valid <= 1'b1;
                        resp_data  <= result_r;
                        resp_flags <= 4'h0;
                        resp_err   <= 2'd2;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: begin
                    OPA_I      <= 4'h0;
                    OPB_I      <= 4'h0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecpu_fabric_bridge.sv
// Self-checking bench for ecpu_fabric_bridge: directed cases plus randomized transactions
// checked against a nibble-list model of the operand stream and the expected response.
module tb_ecpu_fabric_bridge;
    localparam int DW  = 32;
    localparam int NB  = DW / 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_a = '0;
    logic [DW-1:0] req_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic [3:0]    resp_flags;
    logic [1:0]    resp_err;
    logic [3:0]    OPA_I, OPB_I;
    logic [3:0]    RES0_O = 4'h0, RES1_O = 4'h0, RES2_O = 4'h0;

    ecpu_fabric_bridge #(.DATA_W(DW), .TIMEOUT(TMO), .TO_W(5)) dut (
        .UserCLK(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_flags(resp_flags), .resp_err(resp_err),
        .OPA_I(OPA_I), .OPB_I(OPB_I), .RES0_O(RES0_O), .RES1_O(RES1_O), .RES2_O(RES2_O)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Fabric response script for one transaction
    logic [3:0] bd [0:15];
    logic [3:0] bf [0:15];
    bit         be [0:15];
    int         nbeats;
    bit         tmo_mode;

    // What was observed, for literal pinning
    logic [63:0] obs_ops;
    logic [DW-1:0] got_data;
    logic [3:0]  got_flags;
    logic [1:0]  got_err;
    int          got_wait;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < nbeats && i < NB; i++) d[4*i +: 4] = bd[i];
        return d;
    endfunction

    function automatic logic [1:0] model_err();
        bit any_err = 1'b0;
        for (int i = 0; i < nbeats; i++) any_err |= be[i];
        if (tmo_mode)         return 2'd2;
        else if (any_err)     return 2'd1;
        else if (nbeats > NB) return 2'd3;
        else                  return 2'd0;
    endfunction

    task automatic stray();
        RES0_O = 4'($urandom);
        RES1_O = 4'($urandom);
        RES2_O = 4'($urandom);
    endtask

    task automatic quiet();
        RES0_O = 4'($urandom);
        RES1_O = {1'($urandom), 3'b000};
        RES2_O = 4'($urandom);
    endtask

    task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit rst_in_resp);
        logic [63:0] ops;
        int n;
        int hold;
        ops = {b, a};
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_a = a; req_b = b;
        stray();
        @(negedge clk);
        req_valid = 1'b0; req_a = DW'($urandom); req_b = DW'($urandom);
        chk("req_ready_busy", req_ready, 1'b0);
        for (int k = 0; k < 2 * NB; k++) begin
            chk("opa_beat", OPA_I, ops[4*k +: 4]);
            chk("opb_beat", OPB_I, (k < NB) ? 4'h8 : ((k == 2 * NB - 1) ? 4'hD : 4'h9));
            obs_ops[4*k +: 4] = OPA_I;
            if (k < 2 * NB - 1) stray();
            else begin RES0_O = 4'h0; RES1_O = 4'h0; RES2_O = 4'h0; end
            @(negedge clk);
        end
        chk("opa_idle_after_send", OPA_I, 4'h0);
        chk("opb_idle_after_send", OPB_I, 4'h0);
        n = 0;
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, 3)) begin
                quiet();
                @(negedge clk); n++;
            end
            RES0_O = bd[i];
            RES1_O = {1'($urandom), be[i], (i == nbeats - 1) && !tmo_mode, 1'b1};
            RES2_O = bf[i];
            @(negedge clk); n++;
        end
        RES0_O = 4'h0; RES1_O = 4'h0; RES2_O = 4'h0;
        while (!resp_valid && n < 200) begin
            @(negedge clk); n++;
        end
        got_wait = n;
        chk("resp_valid_within_bound", resp_valid, 1'b1);
        got_data = resp_data; got_flags = resp_flags; got_err = resp_err;
        chk("resp_data", resp_data, model_data());
        chk("resp_err", resp_err, model_err());
        if (!tmo_mode && nbeats > 0) chk("resp_flags", resp_flags, bf[nbeats-1]);
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
            stray();
            @(negedge clk);
            chk("resp_valid_held", resp_valid, 1'b1);
            chk("resp_data_stable", resp_data, got_data);
            chk("req_ready_in_resp", req_ready, 1'b0);
        end
        if (rst_in_resp) begin
            stray();
            reset = 1'b1;
            #1;
            chk("rst_resp_valid", resp_valid, 1'b0);
            chk("rst_opb", OPB_I, 4'h0);
            chk("rst_req_ready", req_ready, 1'b1);
            @(negedge clk);
            reset = 1'b0;
            quiet();
        end else begin
            resp_ready = 1'b1;
            stray();
            @(negedge clk);
            resp_ready = 1'b0;
            chk("resp_valid_drop", resp_valid, 1'b0);
            chk("req_ready_after_resp", req_ready, 1'b1);
            quiet();
        end
    endtask

    task automatic set_beats(input int n, input bit tmo);
        nbeats = n;
        tmo_mode = tmo;
        for (int i = 0; i < 16; i++) begin
            bd[i] = 4'($urandom);
            bf[i] = 4'($urandom);
            be[i] = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_opa", OPA_I, 4'h0);
        chk("reset_opb", OPB_I, 4'h0);
        chk("reset_resp_valid", resp_valid, 1'b0);
        chk("reset_resp_data", resp_data, 32'h0);
        chk("reset_resp_flags", resp_flags, 4'h0);
        chk("reset_resp_err", resp_err, 2'd0);
        reset = 1'b0;

        // Full 8-beat result, flags 5
        set_beats(8, 1'b0);
        for (int i = 0; i < 8; i++) bd[i] = 4'(i + 1);
        bf[7] = 4'h5;
        run_txn(32'h12345678, 32'h9ABCDEF0, 1'b0);
        chk("lit_opa_sequence", obs_ops, 64'h9ABCDEF0_12345678);
        chk("lit_data_87654321", got_data, 32'h87654321);
        chk("lit_flags_5", got_flags, 4'h5);
        chk("lit_err_ok", got_err, 2'd0);

        // Short 2-beat result
        set_beats(2, 1'b0);
        bd[0] = 4'h3; bd[1] = 4'hA;
        run_txn(32'($urandom), 32'($urandom), 1'b0);
        chk("lit_data_a3", got_data, 32'h000000A3);
        chk("lit_err_short", got_err, 2'd0);

        // No response at all: timeout
        set_beats(0, 1'b1);
        run_txn(32'($urandom), 32'($urandom), 1'b0);
        chk("lit_timeout_cycles", got_wait, TMO);
        chk("lit_timeout_err", got_err, 2'd2);
        chk("lit_timeout_data", got_data, 32'h0);

        // Partial result then silence
        set_beats(3, 1'b1);
        run_txn(32'($urandom), 32'($urandom), 1'b0);

        // Overflow: 9 beats
        set_beats(9, 1'b0);
        run_txn(32'($urandom), 32'($urandom), 1'b0);
        chk("lit_overflow_err", got_err, 2'd3);

        // Error on a middle beat
        set_beats(3, 1'b0);
        be[1] = 1'b1;
        run_txn(32'($urandom), 32'($urandom), 1'b0);
        chk("lit_error_err", got_err, 2'd1);

        // Error on the overflowing beat: error wins
        set_beats(10, 1'b0);
        be[9] = 1'b1;
        run_txn(32'($urandom), 32'($urandom), 1'b0);
        chk("lit_error_over_overflow", got_err, 2'd1);

        // Reset in beat 5 of SEND
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'hCAFEF00D; req_b = 32'h0BADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_opb_active", OPB_I, 4'h8);
        reset = 1'b1;
        #1;
        chk("rst_send_opb", OPB_I, 4'h0);
        chk("rst_send_opa", OPA_I, 4'h0);
        chk("rst_send_resp_valid", resp_valid, 1'b0);
        chk("rst_send_req_ready", req_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        set_beats(4, 1'b0);
        run_txn(32'h0F1E2D3C, 32'h4B5A6978, 1'b0);

        // Reset while the response is held
        set_beats(5, 1'b0);
        run_txn(32'($urandom), 32'($urandom), 1'b1);
        set_beats(8, 1'b0);
        run_txn(32'h13579BDF, 32'h2468ACE0, 1'b0);
        chk("lit_after_reset_ops", obs_ops, 64'h2468ACE0_13579BDF);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            set_beats($urandom_range(1, 10), ($urandom_range(0, 5) == 0));
            for (int i = 0; i < nbeats; i++) be[i] = ($urandom_range(0, 7) == 0);
            run_txn(32'($urandom), 32'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
